vid_pixel_timing: RTL and testbench

- Display-side stage directly downstream of the video controller's register/RGB-fetch logic.
- Generates the raster from programmed h1/h2/v1/v2 geometry and the cr pixel divider: horizontal/vertical counters, sync and blank strobes.
- Pops fetched RGB words from the pixel FIFO during active video and drives registered R/G/B.
- Issues a per-line fetch request back to the fetch engine and flags FIFO underrun.

---
 rtl/vid_pkg.sv | 51 +++++
 rtl/vid_axis_counter.sv | 44 ++++
 rtl/vid_pixel_timing.sv | 156 +++++++++++++++
 tb/tb_vid_pixel_timing.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared video-controller types: register-field structs, timing state and RGB layout.
// Used by the register block and by the display-side pixel timing stage.
package vid_pkg;

  localparam int VID_CW = 13;
  localparam int VID_PW = 6;

  localparam int VID_R_LSB = 16;
  localparam int VID_G_LSB = 8;
  localparam int VID_B_LSB = 0;

  typedef struct packed {
    logic [VID_CW-1:0] hend;
    logic [VID_CW-1:0] hsize;
  } vid_h1_t;

  typedef struct packed {
    logic [VID_CW-1:0] hsync_start;
    logic [VID_CW-1:0] hsync_end;
  } vid_h2_t;

  typedef struct packed {
    logic [VID_CW-1:0] vend;
    logic [VID_CW-1:0] vsize;
  } vid_v1_t;

  typedef struct packed {
    logic [VID_CW-1:0] vsync_start;
    logic [VID_CW-1:0] vsync_end;
  } vid_v2_t;

  typedef struct packed {
    logic              en;
    logic [VID_PW-1:0] pcnt;
  } vid_cr_t;

  // Snapshot of everything the raster needs; held constant for a whole frame.
  typedef struct packed {
    vid_h1_t           h1;
    vid_h2_t           h2;
    vid_v1_t           v1;
    vid_v2_t           v2;
    logic [VID_PW-1:0] pcnt;
  } vid_geom_t;

  typedef enum logic {
    VT_IDLE = 1'b0,
    VT_RUN  = 1'b1
  } vid_tstate_e;

endpackage

// File: rtl/vid_axis_counter.sv
// One raster axis: step-gated counter wrapping at end-1, with blank and sync-window compares.
module vid_axis_counter
  import vid_pkg::*;
#(
  parameter int CW = VID_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [CW-1:0] end_i,
  input  logic [CW-1:0] size_i,
  input  logic [CW-1:0] sync_start_i,
  input  logic [CW-1:0] sync_end_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] nxt_o,
  output logic          last_o,
  output logic          blank_o,
  output logic          sync_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o  = (cnt_q == end_i - CW'(1));
  assign nxt_o   = last_o ? '0 : cnt_q + CW'(1);
  assign cnt_o   = cnt_q;
  assign blank_o = (cnt_q >= size_i);
  // An empty window (start >= end) can never satisfy both compares.
  assign sync_o  = (cnt_q >= sync_start_i) && (cnt_q < sync_end_i);

  // NOTE: default first so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (adv_i) cnt_d = nxt_o;
  end

  // NOTE: state updates use <= so all flops sample the pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vid_pixel_timing.sv
// Raster generator: pixel divider, h/v counters, sync/blank strobes, FIFO pop to registered RGB,
// per-line fetch requests and sticky underrun detection.
module vid_pixel_timing
  import vid_pkg::*;
#(
  parameter int CW = VID_CW,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [5:0]    pcnt,
  input  logic [CW-1:0] hend,
  input  logic [CW-1:0] hsize,
  input  logic [CW-1:0] hsync_start,
  input  logic [CW-1:0] hsync_end,
  input  logic [CW-1:0] vend,
  input  logic [CW-1:0] vsize,
  input  logic [CW-1:0] vsync_start,
  input  logic [CW-1:0] vsync_end,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_pop,
  output logic          line_req,
  output logic [CW-1:0] line_num,
  output logic          frame_start,
  input  logic          underrun_clr,
  output logic          underrun,
  output logic          hsync,
  output logic          hblank,
  output logic          vsync,
  output logic          vblank,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B
);

  vid_tstate_e   state_q;
  vid_geom_t     geom_q, geom_in;
  logic [5:0]    div_q;
  logic          hsync_q, hblank_q, vsync_q, vblank_q;
  logic          line_req_q, frame_start_q, underrun_q;
  logic [CW-1:0] line_num_q;
  logic [23:0]   rgb_q;

  logic          tick, run, run_tick, start, active, underrun_set;
  logic [CW-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic          h_last, h_blank, h_sync, v_last, v_blank, v_sync;
  logic          unused_pix;

  assign geom_in = '{h1:   '{hend: hend, hsize: hsize},
                     h2:   '{hsync_start: hsync_start, hsync_end: hsync_end},
                     v1:   '{vend: vend, vsize: vsize},
                     v2:   '{vsync_start: vsync_start, vsync_end: vsync_end},
                     pcnt: pcnt};

  assign tick     = (div_q == geom_q.pcnt);
  // Dropping en stops all activity in the same clk; nothing is popped while aborting.
  assign run      = (state_q == VT_RUN) && en;
  assign run_tick = run && tick;
  assign start    = (state_q == VT_IDLE) && en && (hend != '0) && (vend != '0);

  vid_axis_counter #(.CW(CW)) u_h (
    .clk(clk), .reset(reset), .clr_i(!run), .adv_i(run_tick),
    .end_i(geom_q.h1.hend), .size_i(geom_q.h1.hsize),
    .sync_start_i(geom_q.h2.hsync_start), .sync_end_i(geom_q.h2.hsync_end),
    .cnt_o(h_cnt), .nxt_o(h_nxt), .last_o(h_last), .blank_o(h_blank), .sync_o(h_sync)
  );

  vid_axis_counter #(.CW(CW)) u_v (
    .clk(clk), .reset(reset), .clr_i(!run), .adv_i(run_tick && h_last),
    .end_i(geom_q.v1.vend), .size_i(geom_q.v1.vsize),
    .sync_start_i(geom_q.v2.vsync_start), .sync_end_i(geom_q.v2.vsync_end),
    .cnt_o(v_cnt), .nxt_o(v_nxt), .last_o(v_last), .blank_o(v_blank), .sync_o(v_sync)
  );

  assign active       = !h_blank && !v_blank;
  assign pix_pop      = run_tick && active && pix_valid;
  assign underrun_set = run_tick && active && !pix_valid;
  assign unused_pix   = ^pix_data[DW-1:24];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= VT_IDLE;
      geom_q        <= '0;
      div_q         <= '0;
      hsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      rgb_q         <= '0;
      line_req_q    <= 1'b0;
      line_num_q    <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      line_req_q    <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        VT_IDLE: begin
          div_q <= '0;
          if (start) begin
            state_q    <= VT_RUN;
            geom_q     <= geom_in;
            line_req_q <= 1'b1;       // prefetch of line 0
            line_num_q <= '0;
          end
        end
        VT_RUN: begin
          if (!en) begin
            state_q    <= VT_IDLE;
            div_q      <= '0;
            hsync_q    <= 1'b0;
            hblank_q   <= 1'b0;
            vsync_q    <= 1'b0;
            vblank_q   <= 1'b0;
            rgb_q      <= '0;
            line_num_q <= '0;
          end else begin
            div_q <= tick ? '0 : div_q + 6'd1;
            if (tick) begin
              hsync_q       <= h_sync;
              hblank_q      <= h_blank;
              vsync_q       <= v_sync;
              vblank_q      <= v_blank;
              rgb_q         <= (active && pix_valid) ? pix_data[23:0] : '0;
              frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
              if ((h_cnt == geom_q.h1.hsize) && (v_nxt < geom_q.v1.vsize)) begin
                line_req_q <= 1'b1;
                line_num_q <= v_nxt;
              end
              // Geometry written mid-frame is picked up only at the frame boundary.
              if (h_last && v_last) geom_q <= geom_in;
            end
          end
        end
        default: state_q <= VT_IDLE;
      endcase
      if (underrun_set)      underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign hblank      = hblank_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign line_req    = line_req_q;
  assign line_num    = line_num_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign R           = rgb_q[VID_R_LSB +: 8];
  assign G           = rgb_q[VID_G_LSB +: 8];
  assign B           = rgb_q[VID_B_LSB +: 8];

endmodule

// File: tb/tb_vid_pixel_timing.sv
// Directed bench for vid_pixel_timing: 10x4 raster (8x3 active) with a counting FIFO model.
module tb_vid_pixel_timing;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  pcnt = '0;
  logic [12:0] hend = '0, hsize = '0, hsync_start = '0, hsync_end = '0;
  logic [12:0] vend = '0, vsize = '0, vsync_start = '0, vsync_end = '0;
  logic        pix_valid = 1'b1;
  logic [31:0] pix_data;
  logic        pix_pop, line_req, frame_start, underrun, underrun_clr = 1'b0;
  logic [12:0] line_num;
  logic        hsync, hblank, vsync, vblank;
  logic [7:0]  R, G, B;
  logic [7:0]  word;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  vid_pixel_timing dut (
    .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
    .hend(hend), .hsize(hsize), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .vend(vend), .vsize(vsize), .vsync_start(vsync_start), .vsync_end(vsync_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_pop(pix_pop),
    .line_req(line_req), .line_num(line_num), .frame_start(frame_start),
    .underrun_clr(underrun_clr), .underrun(underrun),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(R), .G(G), .B(B)
  );

  always #5 clk = ~clk;

  // FIFO model: head word n carries R=n, G=~n, B=n^5A.
  always @(posedge clk or negedge reset)
    if (!reset)       word <= '0;
    else if (pix_pop) word <= word + 8'd1;
  assign pix_data = {8'hEE, word, ~word, word ^ 8'h5A};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({pix_pop, line_req, line_num, frame_start, underrun,
                hsync, hblank, vsync, vblank, R, G, B});
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_geom(input int he, input int hs, input int hss, input int hse,
                          input int ve, input int vs, input int vss, input int vse,
                          input int pc);
    hend = 13'(he); hsize = 13'(hs); hsync_start = 13'(hss); hsync_end = 13'(hse);
    vend = 13'(ve); vsize = 13'(vs); vsync_start = 13'(vss); vsync_end = 13'(vse);
    pcnt = 6'(pc);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; en = 1'b0; underrun_clr = 1'b0; pix_valid = 1'b1;
    #13;
    check({tag, "_rst_outs"}, outs_vec(), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick_clk();
  endtask

  // After this returns, cyc==0 marks the sample just after the entry edge.
  task automatic enter();
    en = 1'b1;
    tick_clk();
    cyc = 0;
  endtask

  int pops, fs, hb, vs, vb, lr, ur;

  initial begin
    // ---- pcnt=0 reference frame, line requests ----
    set_geom(10, 8, 8, 9, 4, 3, 3, 4, 0);
    do_reset("t1");
    enter();
    pops = 0; fs = 0; hb = 0; vs = 0; vb = 0; lr = 0; ur = 0;
    for (int k = 0; k <= 80; k++) begin
      if (k < 40) pops += int'(pix_pop);
      if (k >= 1 && k <= 40) begin
        hb += int'(hblank); vs += int'(vsync); vb += int'(vblank); lr += int'(line_req);
      end
      fs += int'(frame_start);
      ur |= int'(underrun);
      case (k)
        0:  begin
              check("t1_entry_req", {line_req, line_num}, {1'b1, 13'd0});
              check("t1_entry_pop", {frame_start, pix_pop}, 2'b01);
            end
        1:  begin
              check("t1_fs0", {frame_start, line_req}, 2'b10);
              check("t1_rgb0", {R, G, B}, 24'h00FF5A);
            end
        2:  check("t1_rgb1", {frame_start, R, G, B}, {1'b0, 24'h01FE5B});
        9:  begin
              check("t1_h8_strobes", {hblank, hsync, R, G, B}, {2'b11, 24'h0});
              check("t1_req_l1", {line_req, line_num}, {1'b1, 13'd1});
            end
        10: check("t1_h9_strobes", {hblank, hsync}, 2'b10);
        11: check("t1_rgb_l1", {hblank, R, G, B}, {1'b0, 24'h08F752});
        19: check("t1_req_l2", {line_req, line_num}, {1'b1, 13'd2});
        29: check("t1_no_req_l2", line_req, 1'b0);
        31: check("t1_v3_strobes", {vsync, vblank, R}, {2'b11, 8'h00});
        39: check("t1_req_l0", {line_req, line_num}, {1'b1, 13'd0});
        41: check("t1_fs1", {frame_start, vsync, vblank, R, G, B}, {3'b100, 24'h18E742});
        default: ;
      endcase
      if (k < 80) tick_clk();
    end
    check("t1_pops", pops, 24);
    check("t1_fs_count", fs, 2);
    check("t1_hblank_cnt", hb, 8);
    check("t1_vsync_cnt", vs, 10);
    check("t1_vblank_cnt", vb, 10);
    check("t1_linereq_cnt", lr, 3);
    check("t1_no_underrun", ur, 0);

    // ---- pcnt=2: values held 3 clks, 120-clk frame ----
    set_geom(10, 8, 8, 9, 4, 3, 3, 4, 2);
    do_reset("t2");
    enter();
    pops = 0; fs = 0;
    for (int k = 0; k <= 125; k++) begin
      if (k < 120) pops += int'(pix_pop);
      fs += int'(frame_start);
      case (k)
        3:   check("t2_fs0", {frame_start, R, G, B}, {1'b1, 24'h00FF5A});
        4:   check("t2_hold1", {frame_start, R, G, B}, {1'b0, 24'h00FF5A});
        5:   check("t2_hold2", {R, G, B}, 24'h00FF5A);
        6:   check("t2_rgb1", {R, G, B}, 24'h01FE5B);
        26:  check("t2_hblank_pre", hblank, 1'b0);
        27:  check("t2_hblank_on", {hblank, line_req, line_num}, {2'b11, 13'd1});
        28:  check("t2_req_width", {hblank, line_req}, 2'b10);
        29:  check("t2_hblank_held", hblank, 1'b1);
        123: check("t2_fs1", frame_start, 1'b1);
        default: ;
      endcase
      if (k < 125) tick_clk();
    end
    check("t2_pops", pops, 24);
    check("t2_fs_count", fs, 2);

    // ---- underrun at (5,1), clr vs set priority ----
    set_geom(10, 8, 8, 9, 4, 3, 3, 4, 0);
    do_reset("t3");
    enter();
    while (cyc < 15) tick_clk();
    check("t3_ur_pre", underrun, 1'b0);
    pix_valid = 1'b0;
    #1;
    check("t3_no_pop", pix_pop, 1'b0);
    tick_clk();
    check("t3_ur_set", {underrun, hblank, R, G, B}, {2'b10, 24'h0});
    pix_valid = 1'b1;
    tick_clk();
    check("t3_ur_sticky", {underrun, R, G, B}, {1'b1, 24'h0DF257});
    pix_valid = 1'b0; underrun_clr = 1'b1;
    tick_clk();
    check("t3_set_beats_clr", {underrun, R}, {1'b1, 8'h00});
    pix_valid = 1'b1;
    tick_clk();
    check("t3_lone_clr", underrun, 1'b0);
    underrun_clr = 1'b0;
    tick_clk();
    check("t3_stays_clear", underrun, 1'b0);

    // ---- abort at (4,2), then re-enable ----
    do_reset("t5");
    enter();
    while (cyc < 24) tick_clk();
    check("t5_pre_abort", {line_num, R, G, B}, {13'd2, 24'h13EC49});
    en = 1'b0;
    tick_clk();
    check("t5_abort_outs", outs_vec(), 64'd0);
    tick_clk();
    check("t5_idle_outs", outs_vec(), 64'd0);
    en = 1'b1;
    tick_clk();
    check("t5_reentry_req", {line_req, line_num, frame_start}, {1'b1, 13'd0, 1'b0});
    tick_clk();
    check("t5_reentry_fs", {frame_start, line_req}, 2'b10);

    // ---- hsize 8->6 mid-frame, then async reset mid-line ----
    set_geom(10, 8, 8, 9, 4, 3, 3, 4, 0);
    do_reset("t6");
    enter();
    while (cyc < 5) tick_clk();
    hsize = 13'd6;
    while (cyc < 7) tick_clk();
    check("t6_old_blank_h6", hblank, 1'b0);
    while (cyc < 19) tick_clk();
    check("t6_old_req", {line_req, line_num}, {1'b1, 13'd2});
    while (cyc < 46) tick_clk();
    check("t6_new_h5", hblank, 1'b0);
    tick_clk();
    check("t6_new_h6", {hblank, line_req, line_num}, {2'b11, 13'd1});
    while (cyc < 50) tick_clk();
    check("t6_pre_reset", {hblank, line_num}, {1'b1, 13'd1});
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_reset", outs_vec(), 64'd0);
    #5;
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
